sram_arbiter: RTL and testbench

//  Shares the single external 16-bit async SRAM (frame buffer) between a display read port and a pixel write port.

---
 rtl/sram_arb_pkg.sv | 25 ++
 rtl/sram_arbiter_if.sv | 41 ++++
 rtl/sram_dq_io.sv | 18 +
 rtl/sram_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding, default widths
// and the helper that sizes the read-streak counter.
package sram_arb_pkg;

   localparam int unsigned ADDR_W_DEF       = 20;
   localparam int unsigned DATA_W_DEF       = 16;
   localparam int unsigned RD_BURST_MAX_DEF = 8;

   typedef enum logic [2:0] {
      StIdle,
      StRdAddr,
      StRdData,
      StWrPulse,
      StWrHold
   } arb_state_e;

   // Bits needed to count 0..burst_max inclusive.
   function automatic int unsigned streak_w(input int unsigned burst_max);
      if (burst_max < 1) begin
         return 1;
      end
      return $clog2(burst_max + 1);
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle for the SRAM arbiter.
//   rd_req/rd_addr -> rd_ack/rd_data   : display read port
//   wr_req/wr_addr/wr_data -> wr_ack   : pixel write port
//   wr_be (only with SRAM_ARB_BYTE_MASK_EN): per-byte write enables, bit1 = upper
// Modports: master = requester side, slave = arbiter side.
interface sram_arbiter_if
   import sram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ack;
   logic [DATA_W-1:0] rd_data;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
`ifdef SRAM_ARB_BYTE_MASK_EN
   logic [1:0]        wr_be;
`endif

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data,
`ifdef SRAM_ARB_BYTE_MASK_EN
      output wr_be,
`endif
      input  rd_ack, rd_data, wr_ack
   );

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
`ifdef SRAM_ARB_BYTE_MASK_EN
      input  wr_be,
`endif
      output rd_ack, rd_data, wr_ack
   );

endinterface

// File: rtl/sram_dq_io.sv
// Tristate buffer for the bidirectional SRAM data bus.
//   oe_i   : drive dout_i onto dq_io when high, release (Z) when low
//   dout_i : data to drive
//   din_o  : whatever is currently on the pins
//   dq_io  : SRAM DQ pins
module sram_dq_io #(
   parameter int unsigned DATA_W = 16
) (
   input  logic              oe_i,
   input  logic [DATA_W-1:0] dout_i,
   output logic [DATA_W-1:0] din_o,
   inout  wire  [DATA_W-1:0] dq_io
);

   assign dq_io = oe_i ? dout_i : {DATA_W{1'bz}};
   assign din_o = dq_io;

endmodule

// File: rtl/sram_arbiter.sv
// Arbiter and access sequencer for one external async 16-bit SRAM shared by a
// display read port and a pixel write port. Sole driver of the SRAM pins; every
// access takes three cycles including the IDLE turnaround cycle.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : read/write request handshakes, see sram_arbiter_if
//   sram_addr         : SRAM address pins
//   sram_dq           : SRAM data pins (bidirectional)
//   ce_n oe_n we_n ub_n lb_n : SRAM active-low controls
// Build option: SRAM_ARB_BYTE_MASK_EN adds bus.wr_be to drive ub_n/lb_n on writes.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned RD_BURST_MAX = RD_BURST_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   sram_arbiter_if.slave     bus,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0] sram_dq,
   output logic              ce_n,
   output logic              oe_n,
   output logic              we_n,
   output logic              ub_n,
   output logic              lb_n
);

   localparam int unsigned StreakW = streak_w(RD_BURST_MAX);

   arb_state_e         state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               ce_n_q, ce_n_d;
   logic               oe_n_q, oe_n_d;
   logic               we_n_q, we_n_d;
   logic               ub_n_q, ub_n_d;
   logic               lb_n_q, lb_n_d;
   logic               dq_oe_q, dq_oe_d;
   logic [DATA_W-1:0]  dq_out_q, dq_out_d;
   logic [DATA_W-1:0]  rd_data_q, rd_data_d;
   logic               rd_ack_q, rd_ack_d;
   logic               wr_ack_q, wr_ack_d;
   logic [StreakW-1:0] streak_q, streak_d;

   logic [DATA_W-1:0]  dq_in;
   logic [1:0]         wr_strb_n;
   logic               streak_full;
   logic               rd_win;
   logic               wr_win;

`ifdef SRAM_ARB_BYTE_MASK_EN
   assign wr_strb_n = ~bus.wr_be;
`else
   assign wr_strb_n = 2'b00;
`endif

   // A waiting write pre-empts reads only once the streak has saturated.
   assign streak_full = (streak_q == StreakW'(RD_BURST_MAX));
   assign rd_win      = bus.rd_req && !(bus.wr_req && streak_full);
   assign wr_win      = bus.wr_req && !rd_win;

   sram_dq_io #(
      .DATA_W (DATA_W)
   ) u_dq_io (
      .oe_i   (dq_oe_q),
      .dout_i (dq_out_q),
      .din_o  (dq_in),
      .dq_io  (sram_dq)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         ce_n_q    <= 1'b1;
         oe_n_q    <= 1'b1;
         we_n_q    <= 1'b1;
         ub_n_q    <= 1'b1;
         lb_n_q    <= 1'b1;
         dq_oe_q   <= 1'b0;
         dq_out_q  <= '0;
         rd_data_q <= '0;
         rd_ack_q  <= 1'b0;
         wr_ack_q  <= 1'b0;
         streak_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         ce_n_q    <= ce_n_d;
         oe_n_q    <= oe_n_d;
         we_n_q    <= we_n_d;
         ub_n_q    <= ub_n_d;
         lb_n_q    <= lb_n_d;
         dq_oe_q   <= dq_oe_d;
         dq_out_q  <= dq_out_d;
         rd_data_q <= rd_data_d;
         rd_ack_q  <= rd_ack_d;
         wr_ack_q  <= wr_ack_d;
         streak_q  <= streak_d;
      end
   end

   // Pin values are registered from the next state so each state's controls
   // appear on the pins for exactly the cycle that state occupies.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      ce_n_d    = ce_n_q;
      oe_n_d    = oe_n_q;
      we_n_d    = we_n_q;
      ub_n_d    = ub_n_q;
      lb_n_d    = lb_n_q;
      dq_oe_d   = dq_oe_q;
      dq_out_d  = dq_out_q;
      rd_data_d = rd_data_q;
      rd_ack_d  = 1'b0;
      wr_ack_d  = 1'b0;
      streak_d  = streak_q;

      unique case (state_q)
         StIdle: begin
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            ub_n_d  = 1'b1;
            lb_n_d  = 1'b1;
            dq_oe_d = 1'b0;
            if (rd_win) begin
               state_d = StRdAddr;
               addr_d  = bus.rd_addr;
               ce_n_d  = 1'b0;
               oe_n_d  = 1'b0;
               ub_n_d  = 1'b0;
               lb_n_d  = 1'b0;
               if (bus.wr_req && !streak_full) begin
                  streak_d = streak_q + StreakW'(1);
               end
            end else if (wr_win) begin
               state_d  = StWrPulse;
               addr_d   = bus.wr_addr;
               ce_n_d   = 1'b0;
               we_n_d   = 1'b0;
               ub_n_d   = wr_strb_n[1];
               lb_n_d   = wr_strb_n[0];
               dq_oe_d  = 1'b1;
               dq_out_d = bus.wr_data;
               streak_d = '0;
            end
         end
         StRdAddr: begin
            state_d = StRdData;
         end
         StRdData: begin
            state_d   = StIdle;
            rd_data_d = dq_in;
            rd_ack_d  = 1'b1;
            ce_n_d    = 1'b1;
            oe_n_d    = 1'b1;
            ub_n_d    = 1'b1;
            lb_n_d    = 1'b1;
         end
         StWrPulse: begin
            // Rising we_n commits the write; addr and data stay put for hold time.
            state_d = StWrHold;
            we_n_d  = 1'b1;
         end
         StWrHold: begin
            state_d  = StIdle;
            wr_ack_d = 1'b1;
            ce_n_d   = 1'b1;
            ub_n_d   = 1'b1;
            lb_n_d   = 1'b1;
            dq_oe_d  = 1'b0;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (!bus.wr_req) begin
         streak_d = '0;
      end
   end

   assign sram_addr   = addr_q;
   assign ce_n        = ce_n_q;
   assign oe_n        = oe_n_q;
   assign we_n        = we_n_q;
   assign ub_n        = ub_n_q;
   assign lb_n        = lb_n_q;
   assign bus.rd_ack  = rd_ack_q;
   assign bus.rd_data = rd_data_q;
   assign bus.wr_ack  = wr_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: SRAM pin model, transaction-level
// reference model, per-cycle pin compare, directed scenarios and random traffic.
module tb_sram_arbiter;
   import sram_arb_pkg::*;

   localparam int unsigned AW   = 20;
   localparam int unsigned DW   = 16;
   localparam int unsigned BMAX = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   logic [AW-1:0] sram_addr;
   wire  [DW-1:0] sram_dq;
   logic          ce_n, oe_n, we_n, ub_n, lb_n;

   sram_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .RD_BURST_MAX (BMAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .sram_addr (sram_addr),
      .sram_dq   (sram_dq),
      .ce_n      (ce_n),
      .oe_n      (oe_n),
      .we_n      (we_n),
      .ub_n      (ub_n),
      .lb_n      (lb_n)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [15:0] init_val(input int i);
      return 16'(i * 257) ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                         input logic [1:0] be);
      return {be[1] ? new_v[15:8] : old_v[15:8], be[0] ? new_v[7:0] : old_v[7:0]};
   endfunction

   // ---------------- SRAM pin model (256 cells, aliased on addr[7:0]) ----------------
   logic [DW-1:0] sram_mem [256];
   logic          mem_init_done = 1'b0;
   wire           sram_drv = !ce_n && !oe_n && we_n;
   assign sram_dq = sram_drv ? sram_mem[sram_addr[7:0]] : {DW{1'bz}};

   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) sram_mem[i] <= init_val(i);
         mem_init_done <= 1'b1;
      end else if (!ce_n && !we_n) begin
         sram_mem[sram_addr[7:0]] <= merge(sram_mem[sram_addr[7:0]], sram_dq, {!ub_n, !lb_n});
      end
   end

   // ---------------- reference model ----------------
   // Each grant opens a two-cycle access window; the ack follows in the next cycle.
   logic [DW-1:0] ref_mem [256];
   logic          ref_init = 1'b0;
   int            m_phase;
   logic          m_is_wr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [1:0]    m_be;
   int            m_streak;
   logic          exp_rd_ack, exp_wr_ack;
   logic [DW-1:0] exp_rd_data;
   wire  [1:0]    cur_be;
`ifdef SRAM_ARB_BYTE_MASK_EN
   assign cur_be = bus.wr_be;
`else
   assign cur_be = 2'b11;
`endif
   wire m_rd_go = bus.rd_req && !(bus.wr_req && m_streak == int'(BMAX));
   wire m_wr_go = bus.wr_req && !m_rd_go;

   always @(posedge clk or posedge rst) begin
      if (!ref_init) begin
         for (int i = 0; i < 256; i++) ref_mem[i] <= init_val(i);
         ref_init <= 1'b1;
      end
      if (rst) begin
         m_phase     <= 0;
         m_is_wr     <= 1'b0;
         m_addr      <= '0;
         m_wdata     <= '0;
         m_be        <= 2'b11;
         m_streak    <= 0;
         exp_rd_ack  <= 1'b0;
         exp_wr_ack  <= 1'b0;
         exp_rd_data <= '0;
      end else begin
         exp_rd_ack <= 1'b0;
         exp_wr_ack <= 1'b0;
         if (m_phase == 0) begin
            if (m_rd_go) begin
               m_phase <= 1;
               m_is_wr <= 1'b0;
               m_addr  <= bus.rd_addr;
            end else if (m_wr_go) begin
               m_phase <= 1;
               m_is_wr <= 1'b1;
               m_addr  <= bus.wr_addr;
               m_wdata <= bus.wr_data;
               m_be    <= cur_be;
            end
         end else if (m_phase == 1) begin
            m_phase <= 2;
            if (m_is_wr) ref_mem[m_addr[7:0]] <= merge(ref_mem[m_addr[7:0]], m_wdata, m_be);
         end else begin
            m_phase <= 0;
            if (m_is_wr) begin
               exp_wr_ack <= 1'b1;
            end else begin
               exp_rd_ack  <= 1'b1;
               exp_rd_data <= ref_mem[m_addr[7:0]];
            end
         end
         if (!bus.wr_req) m_streak <= 0;
         else if (m_phase == 0 && m_wr_go) m_streak <= 0;
         else if (m_phase == 0 && m_rd_go) m_streak <= (m_streak < int'(BMAX)) ? m_streak + 1
                                                                               : int'(BMAX);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      logic e_ce, e_oe, e_we, e_ub, e_lb, e_drv;
      forever begin
         @(negedge clk);
         e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_ub = 1'b1; e_lb = 1'b1; e_drv = 1'b0;
         if (m_phase != 0) begin
            e_ce = 1'b0;
            if (!m_is_wr) begin
               e_oe = 1'b0; e_ub = 1'b0; e_lb = 1'b0;
            end else begin
               e_drv = 1'b1;
               e_we  = (m_phase == 1) ? 1'b0 : 1'b1;
               e_ub  = ~m_be[1];
               e_lb  = ~m_be[0];
            end
         end
         chk("ce_n", 32'(ce_n), 32'(e_ce));
         chk("oe_n", 32'(oe_n), 32'(e_oe));
         chk("we_n", 32'(we_n), 32'(e_we));
         chk("ub_n", 32'(ub_n), 32'(e_ub));
         chk("lb_n", 32'(lb_n), 32'(e_lb));
         chk("sram_addr", 32'(sram_addr), 32'(m_addr));
         chk("dq_drive", 32'(dut.u_dq_io.oe_i), 32'(e_drv));
         if (e_drv) chk("dq_wdata", 32'(sram_dq), 32'(m_wdata));
         chk("rd_ack", 32'(bus.rd_ack), 32'(exp_rd_ack));
         chk("wr_ack", 32'(bus.wr_ack), 32'(exp_wr_ack));
         chk("rd_data", 32'(bus.rd_data), 32'(exp_rd_data));
         chk("oe_we_both_low", 32'(!oe_n && !we_n), 32'd0);
         chk("drive_while_oe", 32'(dut.u_dq_io.oe_i && !oe_n), 32'd0);
      end
   endtask

   // Both tasks start and return just after a rising edge.
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int lat, output int we_lows);
      bus.wr_req  = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      lat = 0;
      we_lows = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (!we_n) we_lows++;
      end while (!bus.wr_ack && lat < 20);
      if (!bus.wr_ack) chk("wr_ack_timeout", 32'(bus.wr_ack), 32'd1);
      bus.wr_req = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, output int lat, output logic [DW-1:0] d);
      bus.rd_req  = 1'b1;
      bus.rd_addr = a;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!bus.rd_ack && lat < 20);
      if (!bus.rd_ack) chk("rd_ack_timeout", 32'(bus.rd_ack), 32'd1);
      d = bus.rd_data;
      bus.rd_req = 1'b0;
   endtask

   initial begin
      int            lat, lows, n, acks, seen;
      logic [DW-1:0] d;
      logic [11:0]   pat;

      bus.rd_req = 1'b0; bus.rd_addr = '0;
      bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
`ifdef SRAM_ARB_BYTE_MASK_EN
      bus.wr_be = 2'b11;
`endif
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk("rst_sram_addr", 32'(sram_addr), 32'd0);
      chk("rst_ctrl", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1F);
      chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single write then read back.
      do_write(20'h00010, 16'hA5C3, lat, lows);
      chk("wr_latency", 32'(lat), 32'd3);
      chk("we_pulse_cycles", 32'(lows), 32'd1);
      chk("sram_cell_a5c3", 32'(sram_mem[8'h10]), 32'hA5C3);
      do_read(20'h00010, lat, d);
      chk("rd_latency", 32'(lat), 32'd3);
      chk("rd_data_a5c3", 32'(d), 32'hA5C3);

      // Contention: 8 reads, 1 write, then reads again.
      bus.rd_req = 1'b1; bus.rd_addr = 20'h00010;
      bus.wr_req = 1'b1; bus.wr_addr = 20'h00011; bus.wr_data = 16'h0F0F;
      pat = '0; acks = 0; n = 0;
      while (acks < 12 && n < 80) begin
         @(posedge clk); #1;
         n++;
         if (bus.rd_ack) begin pat = {pat[10:0], 1'b0}; acks++; end
         if (bus.wr_ack) begin pat = {pat[10:0], 1'b1}; acks++; end
      end
      bus.rd_req = 1'b0; bus.wr_req = 1'b0;
      chk("contention_acks", 32'(acks), 32'd12);
      chk("contention_order", 32'(pat), 32'h008);

      // Reset during WR_PULSE.
      bus.wr_req = 1'b1; bus.wr_addr = 20'h00020; bus.wr_data = 16'hBEEF;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (we_n && n < 10);
      chk("we_low_seen", 32'(we_n), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_ctrl", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1F);
      chk("rst_mid_drive", 32'(dut.u_dq_io.oe_i), 32'd0);
      seen = 0;
      repeat (3) begin @(posedge clk); #1; if (bus.wr_ack) seen++; end
      chk("rst_no_ack", 32'(seen), 32'd0);
      rst = 1'b0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!bus.wr_ack && lat < 20);
      bus.wr_req = 1'b0;
      chk("reissue_latency", 32'(lat), 32'd3);
      chk("reissue_cell", 32'(sram_mem[8'h20]), 32'hBEEF);

`ifdef SRAM_ARB_BYTE_MASK_EN
      bus.wr_be = 2'b11;
      do_write(20'h00030, 16'hFFFF, lat, lows);
      bus.wr_be = 2'b01;
      do_write(20'h00030, 16'h1234, lat, lows);
      do_read(20'h00030, lat, d);
      chk("byte_mask_lower", 32'(d), 32'hFF34);
      bus.wr_be = 2'b00;
      do_write(20'h00030, 16'h0000, lat, lows);
      chk("be00_latency", 32'(lat), 32'd3);
      do_read(20'h00030, lat, d);
      chk("be00_no_change", 32'(d), 32'hFF34);
`endif

      // Random traffic against the reference model.
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk); #1;
         if (bus.rd_ack) begin
            if ($urandom_range(0, 1) == 0) bus.rd_req = 1'b0;
            else bus.rd_addr = AW'($urandom);
         end else if (!bus.rd_req && $urandom_range(0, 2) == 0) begin
            bus.rd_req  = 1'b1;
            bus.rd_addr = AW'($urandom);
         end
         if (bus.wr_ack) begin
            if ($urandom_range(0, 1) == 0) begin
               bus.wr_req = 1'b0;
            end else begin
               bus.wr_addr = AW'($urandom);
               bus.wr_data = DW'($urandom);
`ifdef SRAM_ARB_BYTE_MASK_EN
               bus.wr_be = 2'($urandom);
`endif
            end
         end else if (!bus.wr_req && $urandom_range(0, 2) == 0) begin
            bus.wr_req  = 1'b1;
            bus.wr_addr = AW'($urandom);
            bus.wr_data = DW'($urandom);
`ifdef SRAM_ARB_BYTE_MASK_EN
            bus.wr_be = 2'($urandom);
`endif
         end
      end
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
